// File: rtl/fp2int_pipe.sv
// fp2int_pipe: pipelined IEEE-754 binary32 to signed OUT_W-bit integer converter.
// Decode/align, round/negate and saturate/flag stages share one stall signal.
module fp2int_pipe #(
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned STAGES = 2,
  parameter bit          SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [2:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_c,
  output logic             out_invalid,
  output logic             out_inexact
);
  localparam int unsigned IW = OUT_W + 2;
  localparam int unsigned LW = IW + 25;
  localparam int unsigned RW = IW + 1;
  // Biased exponents from here up cannot fit the aligned integer part.
  localparam logic [7:0]       EBig = 8'(OUT_W + 129);
  localparam logic [RW-1:0]    Lim  = RW'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] Min  = {1'b1, {(OUT_W-1){1'b0}}};

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_c;
  logic             r_out_invalid;
  logic             r_out_inexact;
  logic             w_adv;

  assign w_adv       = !r_out_valid || out_ready;
  assign in_ready    = w_adv;
  assign out_valid   = r_out_valid;
  assign out_c       = r_out_c;
  assign out_invalid = r_out_invalid;
  assign out_inexact = r_out_inexact;

  // Stage A: decode and align into integer part, guard and sticky.
  logic [7:0]    w_e;
  logic [23:0]   w_m;
  logic [7:0]    w_sh;
  logic [LW-1:0] w_vec;
  logic          w_a_sign, w_a_nan, w_a_spec, w_a_guard, w_a_sticky;
  logic [IW-1:0] w_a_int;

  assign w_e   = in_a[30:23];
  assign w_m   = {1'b1, in_a[22:0]};
  assign w_sh  = w_e - 8'd125;
  assign w_vec = LW'(w_m) << w_sh;

  always_comb begin
    w_a_sign   = in_a[31];
    w_a_nan    = (w_e == 8'hFF) && (in_a[22:0] != 23'd0);
    w_a_spec   = (w_e == 8'hFF) || (w_e >= EBig);
    w_a_int    = '0;
    w_a_guard  = 1'b0;
    w_a_sticky = 1'b0;
    if (w_e != 8'd0 && !w_a_spec) begin
      if (w_e < 8'd126) begin
        w_a_sticky = 1'b1;
      end else begin
        w_a_int    = w_vec[LW-1:25];
        w_a_guard  = w_vec[24];
        w_a_sticky = |w_vec[23:0];
      end
    end
  end

  logic          w_b_vld, w_b_sign, w_b_nan, w_b_spec, w_b_guard, w_b_sticky;
  logic [IW-1:0] w_b_int;
  logic [2:0]    w_b_rm;

  if (STAGES >= 2) begin : g_reg_a
    logic          r_a_vld, r_a_sign, r_a_nan, r_a_spec, r_a_guard, r_a_sticky;
    logic [IW-1:0] r_a_int;
    logic [2:0]    r_a_rm;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_a_vld <= 1'b0;
      end else if (w_adv) begin
        r_a_vld <= in_valid;
        if (in_valid) begin
          r_a_sign   <= w_a_sign;
          r_a_nan    <= w_a_nan;
          r_a_spec   <= w_a_spec;
          r_a_guard  <= w_a_guard;
          r_a_sticky <= w_a_sticky;
          r_a_int    <= w_a_int;
          r_a_rm     <= in_rm;
        end
      end
    end
    assign w_b_vld    = r_a_vld;
    assign w_b_sign   = r_a_sign;
    assign w_b_nan    = r_a_nan;
    assign w_b_spec   = r_a_spec;
    assign w_b_guard  = r_a_guard;
    assign w_b_sticky = r_a_sticky;
    assign w_b_int    = r_a_int;
    assign w_b_rm     = r_a_rm;
  end else begin : g_comb_a
    assign w_b_vld    = in_valid;
    assign w_b_sign   = w_a_sign;
    assign w_b_nan    = w_a_nan;
    assign w_b_spec   = w_a_spec;
    assign w_b_guard  = w_a_guard;
    assign w_b_sticky = w_a_sticky;
    assign w_b_int    = w_a_int;
    assign w_b_rm     = in_rm;
  end

  // Stage B: round the magnitude, then apply the sign.
  logic             w_inc, w_b_inx;
  logic [RW-1:0]    w_b_rnd;
  logic [OUT_W-1:0] w_b_mag, w_b_val;

  always_comb begin
    case (w_b_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = w_b_sign && (w_b_guard || w_b_sticky);
      3'b011:  w_inc = !w_b_sign && (w_b_guard || w_b_sticky);
      3'b100:  w_inc = w_b_guard;
      default: w_inc = w_b_guard && (w_b_sticky || w_b_int[0]);
    endcase
  end

  assign w_b_rnd = {1'b0, w_b_int} + RW'(w_inc);
  assign w_b_mag = w_b_rnd[OUT_W-1:0];
  assign w_b_val = w_b_sign ? -w_b_mag : w_b_mag;
  assign w_b_inx = w_b_guard || w_b_sticky;

  logic             w_c_vld, w_c_sign, w_c_nan, w_c_spec, w_c_inx_raw;
  logic [RW-1:0]    w_c_rnd;
  logic [OUT_W-1:0] w_c_val;

  if (STAGES >= 3) begin : g_reg_b
    logic             r_b_vld, r_b_sign, r_b_nan, r_b_spec, r_b_inx;
    logic [RW-1:0]    r_b_rnd;
    logic [OUT_W-1:0] r_b_val;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_b_vld <= 1'b0;
      end else if (w_adv) begin
        r_b_vld <= w_b_vld;
        if (w_b_vld) begin
          r_b_sign <= w_b_sign;
          r_b_nan  <= w_b_nan;
          r_b_spec <= w_b_spec;
          r_b_inx  <= w_b_inx;
          r_b_rnd  <= w_b_rnd;
          r_b_val  <= w_b_val;
        end
      end
    end
    assign w_c_vld     = r_b_vld;
    assign w_c_sign    = r_b_sign;
    assign w_c_nan     = r_b_nan;
    assign w_c_spec    = r_b_spec;
    assign w_c_inx_raw = r_b_inx;
    assign w_c_rnd     = r_b_rnd;
    assign w_c_val     = r_b_val;
  end else begin : g_comb_b
    assign w_c_vld     = w_b_vld;
    assign w_c_sign    = w_b_sign;
    assign w_c_nan     = w_b_nan;
    assign w_c_spec    = w_b_spec;
    assign w_c_inx_raw = w_b_inx;
    assign w_c_rnd     = w_b_rnd;
    assign w_c_val     = w_b_val;
  end

  // Stage C: range check, saturation and flags.
  logic             w_c_inv, w_c_inx;
  logic [OUT_W-1:0] w_c_res;

  always_comb begin
    w_c_inv = w_c_spec || (w_c_sign ? (w_c_rnd > Lim) : (w_c_rnd >= Lim));
    w_c_inx = w_c_inx_raw && !w_c_inv;
    w_c_res = w_c_val;
    if (w_c_inv) begin
      if (!SAT) begin
        w_c_res = Min;
      end else begin
        w_c_res = (w_c_sign && !w_c_nan) ? Min : ~Min;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_c       <= '0;
      r_out_invalid <= 1'b0;
      r_out_inexact <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_c_vld;
      if (w_c_vld) begin
        r_out_c       <= w_c_res;
        r_out_invalid <= w_c_inv;
        r_out_inexact <= w_c_inx;
      end
    end
  end

endmodule

// File: tb/tb_fp2int_pipe.sv
// Self-checking bench for fp2int_pipe: three configurations checked against a
// remainder-based rounding model.
module tb_fp2int_pipe;
  localparam int unsigned MW = 32;
  localparam int unsigned MS = 2;
  localparam int unsigned SS = 3;
  localparam int unsigned WW = 64;
  localparam int unsigned WS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_valid_x, out_ready, out_ready_x;
  logic [31:0] in_a;
  logic [2:0]  in_rm;

  logic          m_in_ready, m_out_valid, m_inv, m_inx;
  logic [MW-1:0] m_out_c;
  logic          s_in_ready, s_out_valid, s_inv, s_inx;
  logic [31:0]   s_out_c;
  logic          w_in_ready, w_out_valid, w_inv, w_inx;
  logic [WW-1:0] w_out_c;

  int n_checks = 0;
  int n_fail = 0;

  fp2int_pipe #(.OUT_W(MW), .STAGES(MS), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_a(in_a),
    .in_rm(in_rm), .out_valid(m_out_valid), .out_ready(out_ready), .out_c(m_out_c),
    .out_invalid(m_inv), .out_inexact(m_inx)
  );

  fp2int_pipe #(.OUT_W(32), .STAGES(SS), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(s_in_ready), .in_a(in_a),
    .in_rm(in_rm), .out_valid(s_out_valid), .out_ready(out_ready_x), .out_c(s_out_c),
    .out_invalid(s_inv), .out_inexact(s_inx)
  );

  fp2int_pipe #(.OUT_W(WW), .STAGES(WS), .SAT(1'b0)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(w_in_ready), .in_a(in_a),
    .in_rm(in_rm), .out_valid(w_out_valid), .out_ready(out_ready_x), .out_c(w_out_c),
    .out_invalid(w_inv), .out_inexact(w_inx)
  );

  // Reference: exact quotient/remainder, remainder compared against one half.
  function automatic logic [65:0] ref_conv(input logic [31:0] a, input logic [2:0] rm,
                                           input int outw, input bit sat);
    logic [127:0] m, q, r, half, mag, lim, v, mask;
    int e, ex, sh, cmp;
    bit s, nan, nz, up, inv;
    s    = a[31];
    e    = int'(a[30:23]);
    ex   = e - 127;
    nan  = (e == 255) && (a[22:0] != 23'd0);
    m    = {104'd0, 1'b1, a[22:0]};
    lim  = 128'd1 << (outw - 1);
    mask = (128'd1 << outw) - 128'd1;
    q = '0; r = '0; half = '0; mag = '0; nz = 0; cmp = -1; up = 0; inv = 0; sh = 0;
    if (e == 0) return 66'd0;
    if (e == 255 || ex >= 64) begin
      inv = 1;
    end else begin
      if (ex >= 23) begin
        q = m << (ex - 23);
      end else if (ex >= 0) begin
        sh   = 23 - ex;
        q    = m >> sh;
        r    = m & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
        nz   = (r != 0);
        cmp  = (r > half) ? 1 : ((r == half) ? 0 : -1);
      end else begin
        nz  = 1;
        cmp = (ex == -1) ? ((a[22:0] == 23'd0) ? 0 : 1) : -1;
      end
      case (rm)
        3'd1:    up = 0;
        3'd2:    up = s && nz;
        3'd3:    up = !s && nz;
        3'd4:    up = (cmp >= 0);
        default: up = (cmp > 0) || (cmp == 0 && q[0]);
      endcase
      mag = q + 128'(up);
      inv = s ? (mag > lim) : (mag >= lim);
    end
    if (inv) v = !sat ? lim : ((!s || nan) ? lim - 128'd1 : -lim);
    else     v = s ? -mag : mag;
    v = v & mask;
    return {inv, nz && !inv, v[63:0]};
  endfunction

  logic [31:0] got_m_c, got_s_c;
  logic [63:0] got_w_c;
  logic        got_m_inv, got_m_inx, got_s_inv, got_s_inx, got_w_inv, got_w_inx;
  int          lat_m, lat_s, lat_w;

  // One operand into all three DUTs; results held (out_ready low) until captured.
  task automatic do_op(input logic [31:0] a, input logic [2:0] rm);
    @(negedge clk);
    in_a = a; in_rm = rm; in_valid = 1'b1; in_valid_x = 1'b1;
    out_ready = 1'b0; out_ready_x = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_valid_x = 1'b0;
    lat_m = -1; lat_s = -1; lat_w = -1;
    for (int k = 1; k <= 8; k++) begin
      if (lat_m < 0 && m_out_valid) lat_m = k;
      if (lat_s < 0 && s_out_valid) lat_s = k;
      if (lat_w < 0 && w_out_valid) lat_w = k;
      if (lat_m > 0 && lat_s > 0 && lat_w > 0) break;
      @(negedge clk);
    end
    got_m_c = m_out_c; got_m_inv = m_inv; got_m_inx = m_inx;
    got_s_c = s_out_c; got_s_inv = s_inv; got_s_inx = s_inx;
    got_w_c = w_out_c; got_w_inv = w_inv; got_w_inx = w_inx;
    out_ready = 1'b1; out_ready_x = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready_x = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_valid_x = 1'b0; out_ready = 1'b0; out_ready_x = 1'b0;
    in_a = '0; in_rm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({m_out_valid, m_out_c, m_inv, m_inx} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got v=%b c=%h inv=%b inx=%b, want all 0",
               m_out_valid, m_out_c, m_inv, m_inx);
    end
    n_checks++;
    if ({s_out_valid, s_out_c, s_inv, s_inx, w_out_valid, w_out_c, w_inv, w_inx} !== '0) begin
      n_fail++;
      $display("FAIL reset_aux: got sat v=%b c=%h wide v=%b c=%h, want all 0",
               s_out_valid, s_out_c, w_out_valid, w_out_c);
    end
    n_checks++;
    if ({m_in_ready, s_in_ready, w_in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b%b%b, want 111", m_in_ready, s_in_ready, w_in_ready);
    end
  endtask

  localparam int NDIR = 16;
  logic [67:0] dir_tab [NDIR] = '{
    {32'h40200000, 3'd0, 32'h00000002, 1'b1}, {32'h40200000, 3'd1, 32'h00000002, 1'b1},
    {32'h40200000, 3'd2, 32'h00000002, 1'b1}, {32'h40200000, 3'd3, 32'h00000003, 1'b1},
    {32'h40200000, 3'd4, 32'h00000003, 1'b1}, {32'hC0200000, 3'd2, 32'hFFFFFFFD, 1'b1},
    {32'hC0200000, 3'd1, 32'hFFFFFFFE, 1'b1}, {32'hC0200000, 3'd0, 32'hFFFFFFFE, 1'b1},
    {32'hC0200000, 3'd4, 32'hFFFFFFFD, 1'b1}, {32'h3F000000, 3'd4, 32'h00000001, 1'b1},
    {32'h3F000000, 3'd0, 32'h00000000, 1'b1}, {32'h3E800000, 3'd3, 32'h00000001, 1'b1},
    {32'h3E800000, 3'd2, 32'h00000000, 1'b1}, {32'h00400000, 3'd3, 32'h00000000, 1'b0},
    {32'h3FC00000, 3'd7, 32'h00000002, 1'b1}, {32'h40400000, 3'd0, 32'h00000003, 1'b0}
  };

  task automatic test_rounding;
    logic [67:0] t;
    for (int i = 0; i < NDIR; i++) begin
      t = dir_tab[i];
      do_op(t[67:36], t[35:33]);
      n_checks++;
      if ({got_m_c, got_m_inv, got_m_inx} !== {t[32:1], 1'b0, t[0]}) begin
        n_fail++;
        $display("FAIL rounding[%0d] a=%h rm=%0d: got c=%h inv=%b inx=%b, want c=%h inv=0 inx=%b",
                 i, t[67:36], t[35:33], got_m_c, got_m_inv, got_m_inx, t[32:1], t[0]);
      end
    end
  endtask

  task automatic test_range;
    do_op(32'hCF000000, 3'd0);
    n_checks++;
    if ({got_m_c, got_m_inv, got_m_inx} !== {32'h80000000, 2'b00}) begin
      n_fail++;
      $display("FAIL range_neg_min: got c=%h inv=%b, want 80000000 inv=0", got_m_c, got_m_inv);
    end
    n_checks++;
    if ({got_w_c, got_w_inv} !== {64'hFFFFFFFF80000000, 1'b0}) begin
      n_fail++;
      $display("FAIL range_neg_min_w64: got c=%h inv=%b, want ffffffff80000000 inv=0",
               got_w_c, got_w_inv);
    end
    do_op(32'h4F000000, 3'd0);
    n_checks++;
    if ({got_m_c, got_m_inv, got_m_inx} !== {32'h80000000, 2'b10}) begin
      n_fail++;
      $display("FAIL range_pos_ovf: got c=%h inv=%b inx=%b, want 80000000 inv=1 inx=0",
               got_m_c, got_m_inv, got_m_inx);
    end
    n_checks++;
    if ({got_s_c, got_s_inv} !== {32'h7FFFFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL range_pos_sat: got c=%h inv=%b, want 7fffffff inv=1", got_s_c, got_s_inv);
    end
    n_checks++;
    if ({got_w_c, got_w_inv} !== {64'h0000000080000000, 1'b0}) begin
      n_fail++;
      $display("FAIL range_pos_w64: got c=%h inv=%b, want 0000000080000000 inv=0",
               got_w_c, got_w_inv);
    end
    do_op(32'h7FC00000, 3'd0);
    n_checks++;
    if ({got_m_c, got_m_inv, got_s_c, got_s_inv, got_w_inv} !==
        {32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL range_nan: got c=%h inv=%b sat c=%h inv=%b w64 inv=%b",
               got_m_c, got_m_inv, got_s_c, got_s_inv, got_w_inv);
    end
    do_op(32'hFF800000, 3'd0);
    n_checks++;
    if ({got_s_c, got_s_inv} !== {32'h80000000, 1'b1}) begin
      n_fail++;
      $display("FAIL range_neg_inf_sat: got c=%h inv=%b, want 80000000 inv=1", got_s_c, got_s_inv);
    end
    do_op(32'hCF000001, 3'd1);
    n_checks++;
    if ({got_m_c, got_m_inv, got_s_c, got_s_inv} !== {32'h80000000, 1'b1, 32'h80000000, 1'b1})
    begin
      n_fail++;
      $display("FAIL range_neg_ovf: got c=%h inv=%b sat c=%h inv=%b",
               got_m_c, got_m_inv, got_s_c, got_s_inv);
    end
    do_op(32'h4EFFFFFF, 3'd0);
    n_checks++;
    if ({got_m_c, got_m_inv} !== {32'h7FFFFF80, 1'b0}) begin
      n_fail++;
      $display("FAIL range_pos_max: got c=%h inv=%b, want 7fffff80 inv=0", got_m_c, got_m_inv);
    end
  endtask

  task automatic test_latency;
    do_op(32'h3F800000, 3'd0);
    n_checks++;
    if (lat_m != MS || lat_s != SS || lat_w != WS) begin
      n_fail++;
      $display("FAIL latency: got %0d/%0d/%0d, want %0d/%0d/%0d",
               lat_m, lat_s, lat_w, MS, SS, WS);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [2:0]  rm;
    logic [65:0] em, es, ew;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = {1'($urandom), 8'($urandom_range(118, 192)), 23'($urandom)};
      rm = 3'($urandom_range(0, 7));
      em = ref_conv(a, rm, 32, 1'b0);
      es = ref_conv(a, rm, 32, 1'b1);
      ew = ref_conv(a, rm, 64, 1'b0);
      do_op(a, rm);
      n_checks++;
      if (lat_m != MS || lat_s != SS || lat_w != WS) begin
        n_fail++;
        $display("FAIL random_latency a=%h: got %0d/%0d/%0d", a, lat_m, lat_s, lat_w);
      end
      n_checks++;
      if ({got_m_inv, got_m_inx, got_m_c} !== {em[65:64], em[31:0]}) begin
        n_fail++;
        $display("FAIL random_main a=%h rm=%0d: got inv=%b inx=%b c=%h, want inv=%b inx=%b c=%h",
                 a, rm, got_m_inv, got_m_inx, got_m_c, em[65], em[64], em[31:0]);
      end
      n_checks++;
      if ({got_s_inv, got_s_inx, got_s_c} !== {es[65:64], es[31:0]}) begin
        n_fail++;
        $display("FAIL random_sat a=%h rm=%0d: got inv=%b inx=%b c=%h, want inv=%b inx=%b c=%h",
                 a, rm, got_s_inv, got_s_inx, got_s_c, es[65], es[64], es[31:0]);
      end
      n_checks++;
      if ({got_w_inv, got_w_inx, got_w_c} !== ew) begin
        n_fail++;
        $display("FAIL random_w64 a=%h rm=%0d: got inv=%b inx=%b c=%h, want inv=%b inx=%b c=%h",
                 a, rm, got_w_inv, got_w_inx, got_w_c, ew[65], ew[64], ew[63:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ops [8];
    logic [2:0]  rms [8];
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [65:0] r;
    logic [31:0] prev_c;
    bit          prev_stall;
    int          sent, got, cyc;
    for (int i = 0; i < 8; i++) begin
      ops[i] = {1'($urandom), 8'($urandom_range(124, 150)), 23'($urandom)};
      rms[i] = 3'($urandom_range(0, 4));
    end
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev_c = '0;
    in_valid_x = 1'b0; out_ready_x = 1'b0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = ops[sent]; in_rm = rms[sent];
      end
      #1;
      n_checks++;
      if (m_in_ready !== !(m_out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL b2b_in_ready cyc=%0d: got %b, want %b",
                 cyc, m_in_ready, !(m_out_valid && !out_ready));
      end
      if (prev_stall) begin
        n_checks++;
        if (m_out_c !== prev_c) begin
          n_fail++;
          $display("FAIL b2b_stall_hold cyc=%0d: got %h, want %h", cyc, m_out_c, prev_c);
        end
      end
      if (m_out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra cyc=%0d: got c=%h, want no result", cyc, m_out_c);
        end else begin
          e = exp_q.pop_front();
          if ({m_inv, m_inx, m_out_c} !== e) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got inv=%b inx=%b c=%h, want inv=%b inx=%b c=%h",
                     got, m_inv, m_inx, m_out_c, e[33], e[32], e[31:0]);
          end
        end
        got++;
      end
      if (in_valid && m_in_ready) begin
        r = ref_conv(ops[sent], rms[sent], 32, 1'b0);
        exp_q.push_back({r[65:64], r[31:0]});
        sent++;
      end
      prev_stall = m_out_valid && !out_ready;
      prev_c     = m_out_c;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 8 || sent != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got sent=%0d received=%0d pending=%0d, want 8/8/0",
               sent, got, exp_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_duplicate k=%0d: got out_valid=%b, want 0", k, m_out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_inflight;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40A00000; in_rm = 3'd0; out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h40C00000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({m_out_valid, m_out_c, m_inv, m_inx, m_in_ready} !== {35'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_inflight: got v=%b c=%h inv=%b inx=%b rdy=%b, want 0/0/0/0/1",
               m_out_valid, m_out_c, m_inv, m_inx, m_in_ready);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (m_out_valid) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_flush: got out_valid=1 after reset, want no result");
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_range();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
